// File: rtl/register_file_if.sv
// rtl/register_file_if.sv - register file access bundle between decode/writeback and the register file
//
// Signals:
//   write  master->slave  write enable
//   read   master->slave  read enable for both read ports
//   rs1    master->slave  read port 1 register name
//   rs2    master->slave  read port 2 register name
//   ws     master->slave  write register name
//   wd     master->slave  write data
//   rd1    slave->master  read port 1 data (registered)
//   rd2    slave->master  read port 2 data (registered)
interface register_file_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
);
    logic                  write;
    logic                  read;
    logic [ADDR_WIDTH-1:0] rs1;
    logic [ADDR_WIDTH-1:0] rs2;
    logic [ADDR_WIDTH-1:0] ws;
    logic [DATA_WIDTH-1:0] wd;
    logic [DATA_WIDTH-1:0] rd1;
    logic [DATA_WIDTH-1:0] rd2;

    modport master (
        output write, read, rs1, rs2, ws, wd,
        input  rd1, rd2
    );

    modport slave (
        input  write, read, rs1, rs2, ws, wd,
        output rd1, rd2
    );
endinterface

// File: rtl/register_file.sv
// rtl/register_file.sv - 32x32 integer register file, two registered read ports, one write port, x0 hardwired to zero
//
// Ports:
//   clk  input   clock, all state updates on the rising edge
//   rst  input   synchronous active-high reset, clears registers and read data
//   rf   slave   register_file_if: write/read enables, rs1/rs2/ws names, wd data, rd1/rd2 read data
//
// Optional feature macro: REGFILE_BYPASS_EN
//   defined   - a read of the register being written in the same cycle returns wd
//   undefined - such a read returns the pre-write value
module register_file #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_REGS   = 32
) (
    input  logic             clk,
    input  logic             rst,
    register_file_if.slave   rf
);

    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
    logic [DATA_WIDTH-1:0] rd1_q;
    logic [DATA_WIDTH-1:0] rd1_d;
    logic [DATA_WIDTH-1:0] rd2_q;
    logic [DATA_WIDTH-1:0] rd2_d;
    logic                  wr_en;

    // x0 writes are dropped here, so regs_q[0] never leaves its reset value.
    assign wr_en = rf.write && (rf.ws != '0);

    always_comb begin
        regs_d = regs_q;
        if (wr_en) begin
            regs_d[rf.ws] = rf.wd;
        end
    end

    always_comb begin
        rd1_d = rd1_q;
        rd2_d = rd2_q;
        if (rf.read) begin
            if (rf.rs1 == '0) begin
                rd1_d = '0;
            end else begin
                rd1_d = regs_q[rf.rs1];
`ifdef REGFILE_BYPASS_EN
                if (wr_en && (rf.rs1 == rf.ws)) begin
                    rd1_d = rf.wd;
                end
`endif
            end
            if (rf.rs2 == '0) begin
                rd2_d = '0;
            end else begin
                rd2_d = regs_q[rf.rs2];
`ifdef REGFILE_BYPASS_EN
                if (wr_en && (rf.rs2 == rf.ws)) begin
                    rd2_d = rf.wd;
                end
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
            rd1_q <= '0;
            rd2_q <= '0;
        end else begin
            regs_q <= regs_d;
            rd1_q  <= rd1_d;
            rd2_q  <= rd2_d;
        end
    end

    assign rf.rd1 = rd1_q;
    assign rf.rd2 = rd2_q;

endmodule

// File: tb/tb_register_file.sv
// tb/tb_register_file.sv - self-checking scoreboard bench for register_file
module tb_register_file;

    logic clk;
    logic rst;

    register_file_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) rf_if ();

    register_file #(
        .DATA_WIDTH(32),
        .ADDR_WIDTH(5),
        .NUM_REGS  (32)
    ) dut (
        .clk(clk),
        .rst(rst),
        .rf (rf_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_compared;
    int n_mismatched;

    logic [31:0] model [32];
    logic [31:0] last_rd1;
    logic [31:0] last_rd2;
    logic [63:0] exp_q [$];

`ifdef REGFILE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    task automatic check_value(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_compared++;
        if (observed !== expected) begin
            n_mismatched++;
            $display("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    function automatic logic [31:0] predict(input logic r, input logic w, input logic [4:0] a_ws,
                                            input logic [31:0] a_wd, input logic [4:0] rs,
                                            input logic [31:0] last);
        if (!r) return last;
        if (rs == 5'd0) return 32'd0;
        if (BYPASS && w && (a_ws != 5'd0) && (a_ws == rs)) return a_wd;
        return model[rs];
    endfunction

    task automatic pop_and_check(input string tag);
        logic [63:0] e;
        if (exp_q.size() == 0) begin
            n_compared++;
            n_mismatched++;
            $display("FAIL %s: observed empty scoreboard expected entry", tag);
            return;
        end
        e = exp_q.pop_front();
        check_value({tag, ".rd1"}, rf_if.rd1, e[63:32]);
        check_value({tag, ".rd2"}, rf_if.rd2, e[31:0]);
    endtask

    task automatic cyc(input logic w, input logic [4:0] a_ws, input logic [31:0] a_wd,
                       input logic r, input logic [4:0] a1, input logic [4:0] a2, input string tag);
        logic [31:0] e1;
        logic [31:0] e2;
        rf_if.write = w;
        rf_if.ws    = a_ws;
        rf_if.wd    = a_wd;
        rf_if.read  = r;
        rf_if.rs1   = a1;
        rf_if.rs2   = a2;
        e1 = predict(r, w, a_ws, a_wd, a1, last_rd1);
        e2 = predict(r, w, a_ws, a_wd, a2, last_rd2);
        exp_q.push_back({e1, e2});
        @(posedge clk);
        #1;
        if (w && a_ws != 5'd0) model[a_ws] = a_wd;
        last_rd1 = e1;
        last_rd2 = e2;
        pop_and_check(tag);
    endtask

    // Reset edge with write and read both asserted; reset must win.
    task automatic do_reset(input string tag);
        rst         = 1'b1;
        rf_if.write = 1'b1;
        rf_if.ws    = 5'd3;
        rf_if.wd    = $urandom;
        rf_if.read  = 1'b1;
        rf_if.rs1   = 5'd3;
        rf_if.rs2   = 5'd4;
        exp_q.push_back(64'd0);
        @(posedge clk);
        #1;
        for (int i = 0; i < 32; i++) model[i] = 32'd0;
        last_rd1 = 32'd0;
        last_rd2 = 32'd0;
        rst = 1'b0;
        pop_and_check(tag);
    endtask

    initial begin
        n_compared   = 0;
        n_mismatched = 0;
        rst          = 1'b1;
        rf_if.write  = 1'b0;
        rf_if.read   = 1'b0;
        rf_if.rs1    = '0;
        rf_if.rs2    = '0;
        rf_if.ws     = '0;
        rf_if.wd     = '0;
        for (int i = 0; i < 32; i++) model[i] = 32'd0;
        last_rd1 = 32'd0;
        last_rd2 = 32'd0;

        do_reset("reset0");

        // Arbitrary writes, then reset clears everything.
        cyc(1, 5'd3, 32'hAAAA5555, 0, 5'd0, 5'd0, "pre_w3");
        cyc(1, 5'd4, 32'h12345678, 1, 5'd3, 5'd0, "pre_w4");
        do_reset("reset_mid");
        cyc(0, 5'd0, 32'd0, 1, 5'd3, 5'd4, "post_rst_rd");

        // Basic write then read.
        cyc(1, 5'd1, 32'd1, 0, 5'd0, 5'd0, "w_r1");
        cyc(0, 5'd0, 32'd0, 1, 5'd1, 5'd0, "rd_r1_r0");

        // Top register name and independent write/read.
        cyc(1, 5'd31, 32'd3, 0, 5'd0, 5'd0, "w_r31");
        cyc(0, 5'd0, 32'd0, 1, 5'd0, 5'd31, "rd_r0_r31");
        cyc(1, 5'd1, 32'd5, 1, 5'd31, 5'd31, "w_r1_rd_r31");
        cyc(0, 5'd0, 32'd0, 1, 5'd1, 5'd31, "rd_r1_r31");

        // x0 write is discarded and never forwarded.
        cyc(1, 5'd0, 32'hDEADBEEF, 1, 5'd0, 5'd0, "w_r0_same");
        cyc(0, 5'd0, 32'd0, 1, 5'd0, 5'd0, "rd_r0");

        // Hold on read=0.
        cyc(0, 5'd0, 32'd0, 1, 5'd1, 5'd1, "rd_r1_same");
        cyc(0, 5'd0, 32'd0, 0, 5'd31, 5'd0, "hold");

        // Same-cycle write/read of one register.
        cyc(1, 5'd7, 32'h1234, 1, 5'd7, 5'd0, "rw_r7");
        cyc(0, 5'd0, 32'd0, 1, 5'd7, 5'd7, "rd_r7");
        cyc(1, 5'd9, 32'hCAFEF00D, 1, 5'd2, 5'd9, "rw_r9_port2");

        // Random traffic concentrated on a few names to exercise collisions.
        for (int k = 0; k < 300; k++) begin
            logic [4:0] a_ws;
            logic [4:0] a1;
            logic [4:0] a2;
            a_ws = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
            a1   = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
            a2   = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
            if (k == 150) do_reset("reset_rand");
            cyc(1'($urandom), a_ws, $urandom, 1'($urandom_range(0, 3) != 0), a1, a2, "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/register_file.md
# register_file

Multi-ported integer register file for the RISC-V core datapath: 32 architectural registers of 32 bits, two synchronous read ports and one synchronous write port. Register x0 is hardwired to zero. Sits between decode (source/destination names) and execute/writeback (operands and results).

## Interface

- Parameters:
- DATA_WIDTH, 32, register width in bits
- ADDR_WIDTH, 5, register-name width
- NUM_REGS, 32, number of registers; must equal 2**ADDR_WIDTH
- Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  reset, synchronous, active-high
- write  input  1  write enable
- read  input  1  read enable for both read ports
- rs1  input  ADDR_WIDTH  read port 1 register name
- rs2  input  ADDR_WIDTH  read port 2 register name
- ws  input  ADDR_WIDTH  write register name
- wd  input  DATA_WIDTH  write data
- rd1  output  DATA_WIDTH  read port 1 data (registered)
- rd2  output  DATA_WIDTH  read port 2 data (registered)

## Operation

- Storage: NUM_REGS × DATA_WIDTH flops, indexed by register name.
- Reset (rst=1 at rising edge): every register, rd1 and rd2 clear to 0. Reset has priority over write and read in the same cycle.
- Write: at rising edge with rst=0 and write=1, regs[ws] <= wd. Writes to ws=0 are discarded; regs[0] stays 0 permanently.
- Read: at rising edge with rst=0 and read=1, rd1 <= value of rs1, rd2 <= value of rs2. Name 0 always returns 0.
- read=0: rd1/rd2 hold their last value.
- rs1 == rs2: both ports return the same value.
- Read and write of the same nonzero register in one cycle: result governed by REGFILE_BYPASS_EN (see Configuration).
- write=1 and read=1 to different registers: independent; both take effect.
- No X propagation: outputs defined from first reset onward.

## Timing

- Write latency: data visible to a read issued in the next cycle.
- Read latency: 1 cycle; rd1/rd2 update on the edge that samples read=1.
- Inputs sampled only at rising clk; no combinational input-to-output paths.
- Reset takes one edge; register contents and outputs are 0 from that edge until first write/read.
- Reset asserted mid-sequence discards any concurrent write and read.

## Configuration

- REGFILE_BYPASS_EN defined: when read=1, write=1, ws≠0 and rsN == ws in the same cycle, rdN receives wd (write-through forwarding), independently per port.
- Undefined: the same case returns the pre-write register value; new value visible from next read.
- ws=0 never forwards, with or without the macro.

## Test plan

- Reset: assert rst one cycle after arbitrary writes -> all reads return 0; rd1=rd2=0 immediately after reset edge.
- Write r1=1, then read rs1=1, rs2=0 -> rd1=1, rd2=0.
- Write r31=3, then read rs1=0, rs2=31 -> rd1=0, rd2=3; then write r1=5, read rs1=1, rs2=31 -> rd1=5, rd2=3.
- Write r0=0xDEADBEEF, then read rs1=0, rs2=0 -> rd1=rd2=0.
- Read r1 (value 5), then read=0 with rs1 changed to 31 -> rd1 stays 5.
- Same-cycle write r7=0x1234 and read rs1=7 (r7 previously 0) -> rd1=0x1234 with REGFILE_BYPASS_EN, rd1=0 without; next read returns 0x1234 in both builds.
